ofdm_lane_serializer: RTL and testbench

- Consumes packed 64-bit in-phase/quadrature words from the symbol generator stage: four 16-bit lanes per word.
- Emits one 16-bit I/Q sample pair per cycle on a valid/ready stream toward the IFFT input stage.
- Tracks position within an N_FFT-sample OFDM symbol and flags start/end of symbol. Counts completed symbols.

---
 rtl/ofdm_pkg.sv | 39 +++
 rtl/ofdm_symbol_counter.sv | 56 +++++
 rtl/ofdm_lane_serializer.sv | 106 ++++++++++
 tb/tb_ofdm_lane_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// ofdm_pkg
// Shared configuration and helpers for the OFDM sample-path blocks.
//   SAMPLE_W  : width of one I or Q sample
//   LANES     : samples packed per input word (lane 0 in the MSBs)
//   N_FFT     : samples per OFDM symbol (multiple of LANES, >= LANES)
//   SYM_CNT_W : width of the completed-symbol counter
// Helpers: clog2 for index widths, lane_extract to pull one sample from a word.
package ofdm_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int LANES     = 4;
    localparam int N_FFT     = 64;
    localparam int SYM_CNT_W = 16;

    // Ceiling log2, never less than 1 so single-entry indices still get a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int WORD_W = SAMPLE_W * LANES;
    localparam int IDX_W  = clog2(N_FFT);
    localparam int LANE_W = clog2(LANES);

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [WORD_W-1:0]          word_t;

    // Lane n of a packed word; lane 0 occupies the most significant sample slot.
    function automatic sample_t lane_extract(input word_t word, input logic [LANE_W-1:0] lane);
        int base;
        base = (LANES - 1 - int'(lane)) * SAMPLE_W;
        return sample_t'(word[base +: SAMPLE_W]);
    endfunction

endpackage

// File: rtl/ofdm_symbol_counter.sv
// ofdm_symbol_counter
// Tracks the sample position inside an N-sample OFDM symbol and counts
// completed symbols. Reused by the cyclic-prefix inserter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sync_clr    : synchronous clear of both counters (wins over advance)
//   advance     : one sample has been transferred this cycle
//   idx         : current sample index within the symbol
//   sym_cnt     : completed symbols, wraps modulo 2^CNT_W
//   sop, eop    : idx is the first / last sample of the symbol
module ofdm_symbol_counter
    import ofdm_pkg::*;
#(
    parameter int N     = N_FFT,
    parameter int CNT_W = SYM_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync_clr,
    input  logic                  advance,
    output logic [clog2(N)-1:0]   idx,
    output logic [CNT_W-1:0]      sym_cnt,
    output logic                  sop,
    output logic                  eop
);

    localparam int CW = clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    logic [CW-1:0]    samp_idx_r;
    logic [CNT_W-1:0] sym_cnt_r;

    // Sample index and symbol counter; the index wrap closes one symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_idx_r <= '0;
            sym_cnt_r  <= '0;
        end else if (sync_clr) begin
            samp_idx_r <= '0;
            sym_cnt_r  <= '0;
        end else if (advance) begin
            if (samp_idx_r == LAST_IDX) begin
                samp_idx_r <= '0;
                sym_cnt_r  <= sym_cnt_r + CNT_W'(1);
            end else begin
                samp_idx_r <= samp_idx_r + CW'(1);
            end
        end
    end

    assign idx     = samp_idx_r;
    assign sym_cnt = sym_cnt_r;
    assign sop     = (samp_idx_r == CW'(0));
    assign eop     = (samp_idx_r == LAST_IDX);

endmodule

// File: rtl/ofdm_lane_serializer.sv
// ofdm_lane_serializer
// Splits packed LANES-wide I/Q words into one I/Q sample pair per cycle for
// the IFFT input, tagging each sample with its position in the OFDM symbol.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   sync_clr            : synchronous clear, drops the held word and counters
//   in_valid/in_ready   : upstream word handshake
//   in_phase/in_quad    : packed I/Q words, lane 0 in the MSBs
//   out_valid/out_ready : downstream sample handshake
//   out_i/out_q         : current sample pair
//   out_sop/out_eop     : first / last sample of a symbol
//   out_idx             : sample index within the symbol
//   sym_cnt             : completed symbols
module ofdm_lane_serializer
    import ofdm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W-1:0]     in_phase,
    input  logic [WORD_W-1:0]     in_quad,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SAMPLE_W-1:0]   out_i,
    output logic [SAMPLE_W-1:0]   out_q,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [IDX_W-1:0]      out_idx,
    output logic [SYM_CNT_W-1:0]  sym_cnt
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    word_t             hold_i_r;
    word_t             hold_q_r;
    logic              hold_valid_r;
    logic [LANE_W-1:0] lane_idx_r;

    logic last_lane_s;
    logic xfer_s;
    logic accept_s;
    logic in_ready_s;
    logic sop_s;
    logic eop_s;

    assign last_lane_s = (lane_idx_r == LAST_LANE);
    assign xfer_s      = hold_valid_r & out_ready;

    // The out_ready -> in_ready path lets the next word load on the same edge
    // the last lane leaves, so words stream with no bubble.
    assign in_ready_s  = ~sync_clr & (~hold_valid_r | (last_lane_s & out_ready));
    assign accept_s    = in_valid & in_ready_s;

    // Holding register and lane pointer; a new word always restarts at lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_i_r     <= '0;
            hold_q_r     <= '0;
            hold_valid_r <= 1'b0;
            lane_idx_r   <= '0;
        end else if (sync_clr) begin
            hold_i_r     <= '0;
            hold_q_r     <= '0;
            hold_valid_r <= 1'b0;
            lane_idx_r   <= '0;
        end else if (accept_s) begin
            hold_i_r     <= in_phase;
            hold_q_r     <= in_quad;
            hold_valid_r <= 1'b1;
            lane_idx_r   <= '0;
        end else if (xfer_s) begin
            if (last_lane_s) begin
                hold_valid_r <= 1'b0;
                lane_idx_r   <= '0;
            end else begin
                lane_idx_r   <= lane_idx_r + LANE_W'(1);
            end
        end
    end

    ofdm_symbol_counter #(
        .N     (N_FFT),
        .CNT_W (SYM_CNT_W)
    ) u_sym_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_clr (sync_clr),
        .advance  (xfer_s),
        .idx      (out_idx),
        .sym_cnt  (sym_cnt),
        .sop      (sop_s),
        .eop      (eop_s)
    );

    // Outputs come straight from the holding register; idle cycles present
    // zeros so nothing downstream ever sees stale or unknown data.
    assign in_ready  = in_ready_s;
    assign out_valid = hold_valid_r;
    assign out_i     = hold_valid_r ? SAMPLE_W'(lane_extract(hold_i_r, lane_idx_r)) : SAMPLE_W'(0);
    assign out_q     = hold_valid_r ? SAMPLE_W'(lane_extract(hold_q_r, lane_idx_r)) : SAMPLE_W'(0);
    assign out_sop   = hold_valid_r & sop_s;
    assign out_eop   = hold_valid_r & eop_s;

endmodule

// File: tb/tb_ofdm_lane_serializer.sv
// Scoreboard bench for ofdm_lane_serializer. Accepted words are expanded into
// expected samples by a simple reference model; a negedge monitor compares
// every presented sample and the handshake/counter state against it.
module tb_ofdm_lane_serializer;
    import ofdm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_clr;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_phase;
    logic [63:0] in_quad;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        out_sop;
    logic        out_eop;
    logic [5:0]  out_idx;
    logic [15:0] sym_cnt;

    always #5 clk = ~clk;

    ofdm_lane_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_clr  (sync_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_phase  (in_phase),
        .in_quad   (in_quad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_idx   (out_idx),
        .sym_cnt   (sym_cnt)
    );

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        int          idx;
    } exp_t;

    exp_t        sb[$];
    int          push_idx;
    logic [15:0] exp_sym;
    int          checks;
    int          errors;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model + monitor, evaluated mid-cycle between edges.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        if (!rst_n) begin
            sb.delete();
            push_idx = 0;
            exp_sym  = 16'd0;
        end else begin
            exp_rdy = !sync_clr && (sb.size() == 0 || (sb.size() == 1 && out_ready));
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, sb.size() != 0);
            chk("sym_cnt", sym_cnt, exp_sym);
            if (out_valid && sb.size() != 0) begin
                e = sb[0];
                chk("out_i", out_i, e.i);
                chk("out_q", out_q, e.q);
                chk("out_idx", out_idx, e.idx);
                chk("out_sop", out_sop, e.idx == 0);
                chk("out_eop", out_eop, e.idx == N_FFT - 1);
            end
            if (sync_clr) begin
                sb.delete();
                push_idx = 0;
                exp_sym  = 16'd0;
            end else begin
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    if (e.idx == N_FFT - 1) exp_sym = exp_sym + 16'd1;
                end
                if (in_valid && in_ready) begin
                    for (int k = 0; k < LANES; k++) begin
                        e.i   = 16'((in_phase >> (16 * (LANES - 1 - k))) & 64'hFFFF);
                        e.q   = 16'((in_quad  >> (16 * (LANES - 1 - k))) & 64'hFFFF);
                        e.idx = push_idx;
                        sb.push_back(e);
                        push_idx = (push_idx + 1) % N_FFT;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [63:0] wi, input logic [63:0] wq);
        int   n;
        logic acc;
        in_phase = wi;
        in_quad  = wq;
        in_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n = n + 1;
            if (n > 200) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        logic acc;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        sync_clr  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_phase  = 64'd0;
        in_quad   = 64'd0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_in_ready", in_ready, 64'd1);
        chk("rst_sym_cnt", sym_cnt, 64'd0);
        chk("rst_out_i", out_i, 64'd0);
        chk("rst_out_q", out_q, 64'd0);
        chk("rst_out_sop", out_sop, 64'd0);
        chk("rst_out_eop", out_eop, 64'd0);
        chk("rst_out_idx", out_idx, 64'd0);
        @(posedge clk);
        #1;

        // Single replicated word, then distinct lanes.
        out_ready = 1'b1;
        send_word(64'h0014_0014_0014_0014, 64'h0028_0028_0028_0028);
        idle(6);
        send_word(64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008);
        idle(6);

        // Realign, then a full symbol of back-to-back words plus one more.
        sync_clr = 1'b1;
        idle(1);
        sync_clr = 1'b0;
        for (int w = 0; w < N_FFT / LANES + 1; w++) send_word(rnd64(), rnd64());
        idle(6);

        // Backpressure on lane 2 for five cycles.
        send_word(rnd64(), rnd64());
        idle(2);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
        idle(6);

        // Clear from scratch, then sync_clr while sample 37 is presented.
        sync_clr = 1'b1;
        idle(1);
        sync_clr = 1'b0;
        fork
            begin
                for (int w = 0; w < 12; w++) send_word(rnd64(), rnd64());
            end
            begin
                n = 0;
                while (n < 400) begin
                    @(posedge clk);
                    #1;
                    n = n + 1;
                    if (out_valid && out_idx == 6'd37) begin
                        sync_clr = 1'b1;
                        @(posedge clk);
                        #1;
                        sync_clr = 1'b0;
                        break;
                    end
                end
                if (n >= 400) chk("sop37_timeout", 64'd1, 64'd0);
            end
        join
        idle(10);

        // Random traffic with occasional clears.
        in_valid = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            sync_clr  = ($urandom_range(0, 199) == 0);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_phase = rnd64();
                in_quad  = rnd64();
            end
        end
        in_valid  = 1'b0;
        sync_clr  = 1'b0;
        out_ready = 1'b1;
        idle(8);

        // Asynchronous reset in the middle of a word.
        send_word(rnd64(), rnd64());
        idle(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send_word(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        idle(6);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n = n + 1;
        end
        #1;
        chk("drain", sb.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
